// File: rtl/mem_stream_loader_if.sv
// Byte-stream in, memory-write out, plus load control; master = loader, slave = host/memory side.
// Registered outputs only, so no combinational paths through this bundle.
interface mem_stream_loader_if #(
  parameter int ADDR_WIDTH = 14
);
  logic                  start;
  logic                  clear;
  logic [ADDR_WIDTH-1:0] base;
  logic [ADDR_WIDTH:0]   nwords;
  logic                  in_valid;
  logic [7:0]            in_data;
  logic                  in_ready;
  logic                  busy;
  logic                  done;
  logic                  mem_write;
  logic [3:0]            mem_wmask;
  logic [31:0]           mem_wdata;
  logic                  mem_wgrubby;
  logic [ADDR_WIDTH-1:0] mem_addr;

  modport master (
    input  start, clear, base, nwords, in_valid, in_data,
    output in_ready, busy, done, mem_write, mem_wmask, mem_wdata, mem_wgrubby, mem_addr
  );

  modport slave (
    output start, clear, base, nwords, in_valid, in_data,
    input  in_ready, busy, done, mem_write, mem_wmask, mem_wdata, mem_wgrubby, mem_addr
  );
endinterface

// File: rtl/mem_stream_loader.sv
// Packs a byte stream little-endian into 32-bit words and writes them to consecutive addresses, optional zero-fill first.
// One write per 4 accepted bytes (5 cycles per word unstalled); in_ready drops during CLEAR and WRITE.
module mem_stream_loader #(
  parameter int ADDR_WIDTH = 14
) (
  input  logic                clk,
  input  logic                rst,
  mem_stream_loader_if.master bus
);

  typedef enum logic [2:0] {IDLE, CLEAR, COLLECT, WRITE, DONE} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH:0]   nwords_q;
  logic [ADDR_WIDTH:0]   idx_q;
  logic [ADDR_WIDTH:0]   idx_inc;
  logic [1:0]            byte_cnt;
  logic [23:0]           word_q;
  logic [31:0]           wdata_q;
  logic                  in_ready_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  write_q;
  logic                  take;

  assign take    = bus.in_valid & in_ready_q;
  assign idx_inc = idx_q + 1'b1;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.start) begin
          if (bus.clear)              state_nxt = CLEAR;
          else if (bus.nwords != '0)  state_nxt = COLLECT;
          else                        state_nxt = DONE;
        end
      end
      // addr_q doubles as the fill counter; all-ones is the last fill address
      CLEAR:   if (&addr_q) state_nxt = (nwords_q != '0) ? COLLECT : DONE;
      COLLECT: if (take && byte_cnt == 2'd3) state_nxt = WRITE;
      WRITE:   state_nxt = (idx_inc == nwords_q) ? DONE : COLLECT;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      base_q     <= '0;
      addr_q     <= '0;
      nwords_q   <= '0;
      idx_q      <= '0;
      byte_cnt   <= '0;
      word_q     <= '0;
      wdata_q    <= '0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      write_q    <= 1'b0;
    end else begin
      state      <= state_nxt;
      in_ready_q <= (state_nxt == COLLECT);
      busy_q     <= (state_nxt == CLEAR) || (state_nxt == COLLECT) || (state_nxt == WRITE);
      done_q     <= (state_nxt == DONE);
      write_q    <= (state_nxt == CLEAR) || (state_nxt == WRITE);

      if (state == IDLE && bus.start) begin
        base_q   <= bus.base;
        nwords_q <= bus.nwords;
        idx_q    <= '0;
        byte_cnt <= '0;
      end

      if (take) begin
        byte_cnt <= byte_cnt + 1'b1;
        case (byte_cnt)
          2'd0:    word_q[7:0]   <= bus.in_data;
          2'd1:    word_q[15:8]  <= bus.in_data;
          2'd2:    word_q[23:16] <= bus.in_data;
          default: word_q        <= word_q;
        endcase
      end

      // Address and data only move when a write is about to be presented
      if (state_nxt == CLEAR) begin
        addr_q  <= (state == CLEAR) ? addr_q + 1'b1 : '0;
        wdata_q <= '0;
      end else if (state_nxt == WRITE) begin
        addr_q  <= base_q + idx_q[ADDR_WIDTH-1:0];
        wdata_q <= {bus.in_data, word_q};
      end

      if (state == WRITE) idx_q <= idx_inc;
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.mem_write   = write_q;
  assign bus.mem_wmask   = {4{write_q}};
  assign bus.mem_wdata   = wdata_q;
  assign bus.mem_wgrubby = 1'b0;
  assign bus.mem_addr    = addr_q;

endmodule

// File: tb/tb_mem_stream_loader.sv
// Directed vector bench for mem_stream_loader: one 14-bit and one 4-bit address instance share clk/rst.
module tb_mem_stream_loader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_stream_loader_if #(.ADDR_WIDTH(14)) if14 ();
  mem_stream_loader_if #(.ADDR_WIDTH(4))  if4 ();

  mem_stream_loader #(.ADDR_WIDTH(14)) u14 (.clk(clk), .rst(rst), .bus(if14.master));
  mem_stream_loader #(.ADDR_WIDTH(4))  u4  (.clk(clk), .rst(rst), .bus(if4.master));

  // Shared stimulus, routed to the instance chosen by sel
  bit          sel = 1'b0;
  logic        start_s = 1'b0, clear_s = 1'b0, in_valid_s = 1'b0;
  logic [13:0] base_s = '0;
  logic [14:0] nw_s = '0;
  logic [7:0]  in_data_s = '0;

  assign if14.start    = start_s & ~sel;
  assign if14.clear    = clear_s;
  assign if14.base     = base_s;
  assign if14.nwords   = nw_s;
  assign if14.in_valid = in_valid_s & ~sel;
  assign if14.in_data  = in_data_s;
  assign if4.start     = start_s & sel;
  assign if4.clear     = clear_s;
  assign if4.base      = base_s[3:0];
  assign if4.nwords    = nw_s[4:0];
  assign if4.in_valid  = in_valid_s & sel;
  assign if4.in_data   = in_data_s;

  logic        rdy_s, busy_s, done_s, write_s, grub_s;
  logic [3:0]  mask_s;
  logic [31:0] wdata_s;
  logic [13:0] addr_s;
  assign rdy_s   = sel ? if4.in_ready    : if14.in_ready;
  assign busy_s  = sel ? if4.busy        : if14.busy;
  assign done_s  = sel ? if4.done        : if14.done;
  assign write_s = sel ? if4.mem_write   : if14.mem_write;
  assign grub_s  = sel ? if4.mem_wgrubby : if14.mem_wgrubby;
  assign mask_s  = sel ? if4.mem_wmask   : if14.mem_wmask;
  assign wdata_s = sel ? if4.mem_wdata   : if14.mem_wdata;
  assign addr_s  = sel ? {10'b0, if4.mem_addr} : if14.mem_addr;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [13:0] wq_addr[$];
  logic [31:0] wq_data[$];
  logic [3:0]  wq_mask[$];
  int          wq_cyc[$];
  int          done_cnt = 0, done_cyc = 0, busy_cnt = 0, rdy_cnt = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (write_s) begin
        wq_addr.push_back(addr_s);
        wq_data.push_back(wdata_s);
        wq_mask.push_back(mask_s);
        wq_cyc.push_back(cyc);
      end
      if (done_s) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (busy_s) busy_cnt++;
      if (rdy_s)  rdy_cnt++;
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".in_ready"}, {63'b0, rdy_s}, 64'd0);
    chk({tag, ".busy"},     {63'b0, busy_s}, 64'd0);
    chk({tag, ".done"},     {63'b0, done_s}, 64'd0);
    chk({tag, ".write"},    {63'b0, write_s}, 64'd0);
    chk({tag, ".grubby"},   {63'b0, grub_s}, 64'd0);
    chk({tag, ".wmask"},    {60'b0, mask_s}, 64'd0);
    chk({tag, ".wdata"},    {32'b0, wdata_s}, 64'd0);
    chk({tag, ".addr"},     {50'b0, addr_s}, 64'd0);
  endtask

  // Field order: sel, clr, gaps, base, nw, w0, w1, a0, a1, nclear
  typedef struct {
    bit          sel;
    bit          clr;
    bit          gaps;
    logic [13:0] base;
    logic [14:0] nw;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [13:0] a0;
    logic [13:0] a1;
    int          nclear;
  } vec_t;

  task automatic run_vec(input vec_t v, input string tag);
    logic [31:0] w;
    logic [13:0] ea;
    int          guard;
    bit          got;
    int          s_cyc;
    int          ewr;
    int          nw;
    nw = int'(v.nw);
    sel = v.sel;
    @(posedge clk); #1;
    wq_addr.delete(); wq_data.delete(); wq_mask.delete(); wq_cyc.delete();
    done_cnt = 0; busy_cnt = 0; rdy_cnt = 0; done_cyc = 0;
    start_s = 1'b1; clear_s = v.clr; base_s = v.base; nw_s = v.nw;
    s_cyc = cyc;
    @(posedge clk); #1;
    start_s = 1'b0;
    for (int k = 0; k < 4 * nw; k++) begin
      w = (k < 4) ? v.w0 : v.w1;
      if (v.gaps) begin
        // idle gaps with stray start pulses that a busy loader must ignore
        repeat ($urandom_range(0, 2)) begin
          in_valid_s = 1'b0;
          in_data_s  = 8'($urandom);
          start_s    = 1'($urandom_range(0, 1));
          base_s     = 14'($urandom);
          @(posedge clk); #1;
        end
        start_s = 1'b0;
      end
      in_valid_s = 1'b1;
      in_data_s  = w[8*(k%4) +: 8];
      got = 1'b0;
      guard = 0;
      while (!got && guard < 100) begin
        @(negedge clk);
        got = rdy_s;
        @(posedge clk); #1;
        guard++;
      end
      in_valid_s = 1'b0;
      if (!got) chk({tag, ".byte_accept_timeout"}, 64'd0, 64'd1);
    end
    guard = 0;
    while (done_cnt == 0 && guard < 60) begin
      @(posedge clk); #1;
      guard++;
    end
    repeat (4) @(posedge clk);
    #1;

    ewr = v.nclear + nw;
    chk({tag, ".nwrites"}, 64'(wq_addr.size()), 64'(ewr));
    if (wq_addr.size() == ewr) begin
      for (int i = 0; i < v.nclear; i++) begin
        chk($sformatf("%s.clr_addr%0d", tag, i), {50'b0, wq_addr[i]}, 64'(i));
        chk($sformatf("%s.clr_data%0d", tag, i), {32'b0, wq_data[i]}, 64'd0);
      end
      for (int j = 0; j < nw; j++) begin
        ea = (j == 0) ? v.a0 : v.a1;
        w  = (j == 0) ? v.w0 : v.w1;
        chk($sformatf("%s.addr%0d", tag, j), {50'b0, wq_addr[v.nclear+j]}, {50'b0, ea});
        chk($sformatf("%s.data%0d", tag, j), {32'b0, wq_data[v.nclear+j]}, {32'b0, w});
        chk($sformatf("%s.mask%0d", tag, j), {60'b0, wq_mask[v.nclear+j]}, 64'hF);
        if (!v.gaps && j > 0)
          chk($sformatf("%s.spacing%0d", tag, j),
              64'(wq_cyc[v.nclear+j] - wq_cyc[v.nclear+j-1]), 64'd5);
      end
      if (ewr > 0) chk({tag, ".done_lat"}, 64'(done_cyc - wq_cyc[ewr-1]), 64'd1);
    end
    chk({tag, ".done_pulses"}, 64'(done_cnt), 64'd1);
    if (!v.gaps) begin
      chk({tag, ".busy_cycles"}, 64'(busy_cnt), 64'(v.nclear + 5 * nw));
      chk({tag, ".ready_cycles"}, 64'(rdy_cnt), 64'(4 * nw));
    end
    if (ewr == 0) chk({tag, ".done_at"}, 64'(done_cyc), 64'(s_cyc + 1));
  endtask

  vec_t vt[6];
  vec_t v6;

  initial begin
    vt[0] = '{0, 0, 0, 14'h010,  15'd2, 32'h44332211, 32'h88776655, 14'h010,  14'h011, 0};
    vt[1] = '{0, 0, 0, 14'h123,  15'd0, 32'h0,        32'h0,        14'h0,    14'h0,   0};
    vt[2] = '{1, 1, 0, 14'd3,    15'd1, 32'hDDCCBBAA, 32'h0,        14'd3,    14'h0,   16};
    vt[3] = '{1, 0, 0, 14'd15,   15'd2, 32'hA1B2C3D4, 32'h0F0E0D0C, 14'd15,   14'd0,   0};
    vt[4] = '{0, 0, 1, 14'h010,  15'd2, 32'h44332211, 32'h88776655, 14'h010,  14'h011, 0};
    vt[5] = '{0, 0, 0, 14'h3FFF, 15'd2, 32'hCAFEF00D, 32'h12345678, 14'h3FFF, 14'h000, 0};
    v6    = '{0, 0, 0, 14'h000,  15'd1, 32'h04030201, 32'h0,        14'h000,  14'h0,   0};

    repeat (2) @(posedge clk);
    #1;
    sel = 1'b0; #1; chk_zero("reset14");
    sel = 1'b1; #1; chk_zero("reset4");
    sel = 1'b0;
    rst = 1'b0;
    repeat (2) @(posedge clk);

    for (int n = 0; n < 6; n++) run_vec(vt[n], $sformatf("vec%0d", n));

    // Reset in the middle of a word, then a clean single-word load
    sel = 1'b0;
    @(posedge clk); #1;
    start_s = 1'b1; clear_s = 1'b0; base_s = 14'h0; nw_s = 15'd1;
    @(posedge clk); #1;
    start_s = 1'b0;
    in_valid_s = 1'b1; in_data_s = 8'hEE;
    @(posedge clk); #1;
    in_data_s = 8'hFF;
    @(posedge clk); #1;
    in_valid_s = 1'b0;
    rst = 1'b1;
    #1; chk_zero("rst_mid_a");
    @(posedge clk); #1;
    chk_zero("rst_mid_b");
    rst = 1'b0;
    @(posedge clk); #1;
    run_vec(v6, "after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 500000");
    $fatal(1);
  end

endmodule
